// File: rtl/vip_axi4_pkg.sv
// Shared AXI4 VIP configuration type; a zero width field selects the block's built-in default.
package vip_axi4_pkg;

    typedef struct packed {
        int unsigned VIP_AXI4_ID_WIDTH_P;
        int unsigned VIP_AXI4_ADDR_WIDTH_P;
        int unsigned VIP_AXI4_DATA_WIDTH_P;
        int unsigned VIP_AXI4_USER_WIDTH_P;
    } vip_axi4_cfg_t;

endpackage

// File: rtl/vip_axi4_rd_responder.sv
// AXI4 read-channel responder: one outstanding AR, FIXED/INCR/WRAP R bursts served from a
// backdoor-loaded word memory, SLVERR with zero data for illegal requests or out-of-range words.
module vip_axi4_rd_responder #(
    parameter vip_axi4_pkg::vip_axi4_cfg_t CFG_P = '{default: '0},
    parameter int MEM_DEPTH_P = 256,
    localparam int ID_W   = (CFG_P.VIP_AXI4_ID_WIDTH_P   != 0) ? int'(CFG_P.VIP_AXI4_ID_WIDTH_P)   : 4,
    localparam int ADDR_W = (CFG_P.VIP_AXI4_ADDR_WIDTH_P != 0) ? int'(CFG_P.VIP_AXI4_ADDR_WIDTH_P) : 32,
    localparam int DATA_W = (CFG_P.VIP_AXI4_DATA_WIDTH_P != 0) ? int'(CFG_P.VIP_AXI4_DATA_WIDTH_P) : 32,
    localparam int USER_W = (CFG_P.VIP_AXI4_USER_WIDTH_P != 0) ? int'(CFG_P.VIP_AXI4_USER_WIDTH_P) : 1,
    localparam int MEM_AW = $clog2(MEM_DEPTH_P)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic [USER_W-1:0] ruser,
    output logic              rvalid,
    input  logic              rready,
    input  logic              mem_wr_en,
    input  logic [MEM_AW-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        cnt_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [MEM_DEPTH_P];

    logic              ar_hs;
    logic              r_hs;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [ADDR_W-1:0] ld_idx;
    logic              ld_err;
    logic              ld_bad;

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] a,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] wbytes;
        logic [ADDR_W-1:0] low;
        logic [ADDR_W-1:0] nxt;
        inc    = ADDR_W'(1) << size;
        wbytes = (ADDR_W'(len) + ADDR_W'(1)) << size;
        low    = a & ~(wbytes - ADDR_W'(1));
        nxt    = a;
        if (burst == 2'd1) begin
            nxt = (a & ~(inc - ADDR_W'(1))) + inc;
        end else if (burst == 2'd2) begin
            nxt = a + inc;
            if (nxt == low + wbytes) nxt = low;
        end
        return nxt;
    endfunction

    // Request-wide errors: reserved burst, beat wider than the bus, or a WRAP length AXI forbids.
    function automatic logic ar_illegal(
        input logic [1:0] burst,
        input logic [7:0] len,
        input logic [2:0] size
    );
        return (burst == 2'd3) ||
               ((32'd8 << size) > 32'(DATA_W)) ||
               ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;
    assign ruser = '0;

    always_comb begin
        ld_en   = 1'b0;
        ld_addr = araddr;
        ld_err  = ar_illegal(arburst, arlen, arsize);
        if (state == ST_IDLE) begin
            ld_en = ar_hs;
        end else begin
            ld_en   = r_hs && !rlast;
            ld_addr = next_addr(addr_q, len_q, size_q, burst_q);
            ld_err  = err_q;
        end
        ld_idx = ld_addr >> BYTE_SH;
        ld_bad = ld_err || ((ld_idx >> MEM_AW) != '0);
    end

    always_ff @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    // Burst bookkeeping only matters inside BURST, so it carries no reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            addr_q <= ld_addr;
            if (state == ST_IDLE) begin
                len_q   <= arlen;
                size_q  <= arsize;
                burst_q <= arburst;
                err_q   <= ld_err;
                cnt_q   <= 8'd0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
        end else if (state == ST_IDLE) begin
            arready <= 1'b1;
            if (ar_hs) begin
                arready <= 1'b0;
                rvalid  <= 1'b1;
                rid     <= arid;
                rdata   <= ld_bad ? '0 : mem[ld_idx[MEM_AW-1:0]];
                rresp   <= ld_bad ? 2'b10 : 2'b00;
                rlast   <= (arlen == 8'd0);
                state   <= ST_BURST;
            end
        end else begin
            arready <= 1'b0;
            if (r_hs) begin
                if (rlast) begin
                    rvalid  <= 1'b0;
                    arready <= 1'b1;
                    state   <= ST_IDLE;
                end else begin
                    rdata <= ld_bad ? '0 : mem[ld_idx[MEM_AW-1:0]];
                    rresp <= ld_bad ? 2'b10 : 2'b00;
                    rlast <= ((cnt_q + 8'd1) == len_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_vip_axi4_rd_responder.sv
// Directed bench for vip_axi4_rd_responder: a burst-level model predicts every R beat and a
// negedge monitor compares the bus against it, including stall stability and idle arready.
module tb_vip_axi4_rd_responder;

    localparam vip_axi4_pkg::vip_axi4_cfg_t CFG = '{
        VIP_AXI4_ID_WIDTH_P:   4,
        VIP_AXI4_ADDR_WIDTH_P: 32,
        VIP_AXI4_DATA_WIDTH_P: 32,
        VIP_AXI4_USER_WIDTH_P: 1
    };

    logic        clk;
    logic        rst_n;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [0:0]  ruser;
    logic        rvalid;
    logic        rready;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;

    vip_axi4_rd_responder #(
        .CFG_P       (CFG),
        .MEM_DEPTH_P (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .ruser       (ruser),
        .rvalid      (rvalid),
        .rready      (rready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mem_m [16];
    int          checks = 0;
    int          errors = 0;
    int          popped = 0;
    logic        stall_prev = 1'b0;
    beat_t       held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected beats straight from the burst rules: each beat's byte address computed directly from its index.
    task automatic push_exp(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int unsigned inc, wb, low, a, idx;
        bit err_all, bad;
        beat_t b;
        inc     = 32'd1 << size;
        err_all = (burst == 2'd3) || ((32'd8 << size) > 32'd32) ||
                  (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        wb  = (int'(len) + 1) * inc;
        low = addr - (addr % wb);
        for (int i = 0; i <= int'(len); i++) begin
            if (burst == 2'd1)      a = (i == 0) ? addr : (addr - addr % inc) + i * inc;
            else if (burst == 2'd2) a = low + ((addr - low) + i * inc) % wb;
            else                    a = addr;
            idx = a / 4;
            bad = err_all || (idx >= 16);
            b.id   = id;
            b.data = 32'h0;
            if (!bad) b.data = mem_m[idx[3:0]];
            b.resp = bad ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 just after the AR handshake edge.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input bit wr, input logic [3:0] wr_idx, input logic [31:0] wr_data);
        int n = 0;
        while (!arready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!arready) begin
            chk("ar_ready_wait", {63'b0, arready}, 64'd1);
            return;
        end
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        mem_wr_en = wr; mem_wr_addr = wr_idx; mem_wr_data = wr_data;
        push_exp(id, addr, len, size, burst);
        if (wr) mem_m[wr_idx] = wr_data;
        @(posedge clk); #1;
        arvalid = 1'b0;
        mem_wr_en = 1'b0;
        chk("ar_to_rvalid_latency", {63'b0, rvalid}, 64'd1);
        chk("arready_drop_after_ar", {63'b0, arready}, 64'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || rvalid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("burst_beats_outstanding", 64'(exp_q.size()), 64'd0);
        chk("arready_after_burst", {63'b0, arready}, 64'd1);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_rid", 64'(rid), 64'(held.id));
                chk("stall_rdata", 64'(rdata), 64'(held.data));
                chk("stall_rresp", 64'(rresp), 64'(held.resp));
                chk("stall_rlast", 64'(rlast), 64'(held.last));
                chk("stall_rvalid", {63'b0, rvalid}, 64'd1);
            end
            if (rvalid) begin
                chk("arready_during_burst", {63'b0, arready}, 64'd0);
                chk("ruser_zero", 64'(ruser), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got rdata %h rid %h, expected no beat", rdata, rid);
                end else begin
                    chk("rid", 64'(rid), 64'(exp_q[0].id));
                    chk("rdata", 64'(rdata), 64'(exp_q[0].data));
                    chk("rresp", 64'(rresp), 64'(exp_q[0].resp));
                    chk("rlast", 64'(rlast), 64'(exp_q[0].last));
                    if (rready) begin
                        exp_q.delete(0);
                        popped++;
                    end
                end
            end
            stall_prev = rvalid && !rready;
            held.id   = rid;
            held.data = rdata;
            held.resp = rresp;
            held.last = rlast;
        end
    end

    initial begin
        int n, base;
        rst_n = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 1'b1; mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            mem_wr_en = 1'b1; mem_wr_addr = i[3:0]; mem_wr_data = 32'hA000_0000 + i;
            mem_m[i] = 32'hA000_0000 + i;
            @(posedge clk); #1;
        end
        mem_wr_en = 1'b0;
        chk("reset_arready", {63'b0, arready}, 64'd0);
        chk("reset_rvalid", {63'b0, rvalid}, 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_rid", 64'(rid), 64'd0);
        chk("reset_rresp", 64'(rresp), 64'd0);
        chk("reset_rlast", {63'b0, rlast}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arready_first_edge", {63'b0, arready}, 64'd1);

        do_ar(4'd5, 32'h10, 8'd3, 3'd2, 2'd1, 1'b0, 4'd0, 32'd0);
        chk("model_incr_count", 64'(exp_q.size()), 64'd4);
        chk("model_incr_b0", 64'(exp_q[0].data), 64'hA000_0004);
        chk("model_incr_b3", 64'(exp_q[3].data), 64'hA000_0007);
        chk("model_incr_last", {63'b0, exp_q[3].last}, 64'd1);
        wait_done();

        do_ar(4'd1, 32'h08, 8'd3, 3'd2, 2'd2, 1'b0, 4'd0, 32'd0);
        chk("model_wrap_b1", 64'(exp_q[1].data), 64'hA000_0003);
        chk("model_wrap_b2", 64'(exp_q[2].data), 64'hA000_0000);
        chk("model_wrap_b3", 64'(exp_q[3].data), 64'hA000_0001);
        wait_done();

        do_ar(4'd2, 32'h04, 8'd2, 3'd2, 2'd0, 1'b0, 4'd0, 32'd0);
        chk("model_fixed_b2", 64'(exp_q[2].data), 64'hA000_0001);
        wait_done();

        base = popped;
        do_ar(4'd3, 32'h00, 8'd3, 3'd2, 2'd1, 1'b0, 4'd0, 32'd0);
        n = 0;
        while (popped < base + 1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("bp_rvalid_held", {63'b0, rvalid}, 64'd1);
        chk("bp_beats_left", 64'(exp_q.size()), 64'd3);
        rready = 1'b1;
        wait_done();

        do_ar(4'd4, 32'h3C, 8'd1, 3'd2, 2'd1, 1'b0, 4'd0, 32'd0);
        chk("model_range_b0", 64'(exp_q[0].data), 64'hA000_000F);
        chk("model_range_b1_resp", 64'(exp_q[1].resp), 64'd2);
        wait_done();

        do_ar(4'd9, 32'h00, 8'd1, 3'd2, 2'd3, 1'b0, 4'd0, 32'd0);
        chk("model_rsvd_b0_resp", 64'(exp_q[0].resp), 64'd2);
        wait_done();
        do_ar(4'd10, 32'h00, 8'd0, 3'd3, 2'd1, 1'b0, 4'd0, 32'd0);
        wait_done();
        do_ar(4'd11, 32'h08, 8'd2, 3'd2, 2'd2, 1'b0, 4'd0, 32'd0);
        wait_done();

        do_ar(4'd6, 32'h10, 8'd0, 3'd2, 2'd1, 1'b1, 4'd4, 32'h1234_5678);
        chk("model_backdoor_old", 64'(exp_q[0].data), 64'hA000_0004);
        wait_done();
        do_ar(4'd6, 32'h10, 8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 32'd0);
        chk("model_backdoor_new", 64'(exp_q[0].data), 64'h1234_5678);
        wait_done();

        base = popped;
        do_ar(4'd7, 32'h00, 8'd7, 3'd2, 2'd1, 1'b0, 4'd0, 32'd0);
        n = 0;
        while (popped < base + 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_rvalid", {63'b0, rvalid}, 64'd0);
        chk("midrst_arready", {63'b0, arready}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_arready_release", {63'b0, arready}, 64'd1);
        chk("midrst_no_residual", {63'b0, rvalid}, 64'd0);
        do_ar(4'd8, 32'h20, 8'd1, 3'd2, 2'd1, 1'b0, 4'd0, 32'd0);
        chk("model_post_reset_b1", 64'(exp_q[1].data), 64'hA000_0009);
        wait_done();
        repeat (5) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end

endmodule
